// File: rtl/goomba_sprite_reader_if.sv
// Video-side bundle for the goomba sprite reader: draw coordinates in, ROM address out,
// ROM colour back in, registered pixel out.
interface goomba_sprite_reader_if;
    logic        frame_start;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        draw_en;
    logic [8:0]  read_address;
    logic        sprite_sel;
    logic [23:0] color_in;
    logic [23:0] pixel_color;
    logic        pixel_hit;

    modport master (
        output frame_start, draw_x, draw_y, draw_en, color_in,
        input  read_address, sprite_sel, pixel_color, pixel_hit
    );

    modport slave (
        input  frame_start, draw_x, draw_y, draw_en, color_in,
        output read_address, sprite_sel, pixel_color, pixel_hit
    );
endinterface

// File: rtl/goomba_sprite_reader.sv
// Frame-synchronised goomba sprite reader: coordinate -> ROM address -> registered pixel,
// plus the walk / squish / gone display life cycle.
//
//   state     | meaning
//   ST_WALK   | alive, walking; mirror toggles every WALK_FRAMES frames
//   ST_SQUISH | stomped; squished sprite shown for SQUISH_FRAMES frames
//   ST_GONE   | removed from play; nothing rendered until respawn
module goomba_sprite_reader #(
    parameter int unsigned SPRITE_W      = 21,
    parameter int unsigned SPRITE_H      = 21,
    parameter logic [23:0] KEY_COLOR     = 24'h800080,
    parameter int unsigned WALK_FRAMES   = 8,
    parameter int unsigned SQUISH_FRAMES = 30
) (
    input  logic                         clk_sys,
    input  logic                         rst_b,
    goomba_sprite_reader_if.slave        vid,
    input  logic [9:0]                   goomba_x_i,
    input  logic [9:0]                   goomba_y_i,
    input  logic                         squish_req_i,
    input  logic                         respawn_i,
    output logic                         gone_o
);
    localparam logic [1:0] ST_WALK   = 2'd0;
    localparam logic [1:0] ST_SQUISH = 2'd1;
    localparam logic [1:0] ST_GONE   = 2'd2;

    localparam int SQ_W = $clog2(SQUISH_FRAMES + 1);
    localparam int AN_W = $clog2(WALK_FRAMES);

    logic [1:0]      state_q, state_d;
    logic [SQ_W-1:0] squish_cnt_q, squish_cnt_d;
    logic [AN_W-1:0] anim_cnt_q, anim_cnt_d;
    logic            mirror_q, mirror_d;

    logic [9:0]      pos_x_q, pos_y_q;
    logic [1:0]      disp_state_q;
    logic            disp_mirror_q;

    logic [8:0]      read_address_q, read_address_d;
    logic            sprite_sel_q, hit_en_q;
    logic [23:0]     pixel_color_q;
    logic            pixel_hit_q;

    always_comb begin
        state_d      = state_q;
        squish_cnt_d = squish_cnt_q;
        anim_cnt_d   = anim_cnt_q;
        mirror_d     = mirror_q;
        if (respawn_i) begin
            state_d      = ST_WALK;
            squish_cnt_d = '0;
            anim_cnt_d   = '0;
            mirror_d     = 1'b0;
        end else begin
            case (state_q)
                ST_WALK: begin
                    if (squish_req_i) begin
                        state_d      = ST_SQUISH;
                        squish_cnt_d = SQ_W'(SQUISH_FRAMES);
                        anim_cnt_d   = '0;
                        mirror_d     = 1'b0;
                    end else if (vid.frame_start) begin
                        if (anim_cnt_q == AN_W'(WALK_FRAMES - 1)) begin
                            anim_cnt_d = '0;
                            mirror_d   = ~mirror_q;
                        end else begin
                            anim_cnt_d = anim_cnt_q + AN_W'(1);
                        end
                    end
                end
                ST_SQUISH: begin
                    if (vid.frame_start) begin
                        if (squish_cnt_q == SQ_W'(1)) begin
                            state_d      = ST_GONE;
                            squish_cnt_d = '0;
                        end else begin
                            squish_cnt_d = squish_cnt_q - SQ_W'(1);
                        end
                    end
                end
                ST_GONE: ;
                default: state_d = ST_WALK;
            endcase
        end
    end

    // Box test in 11 bits so a sprite parked near x/y = 1023 never wraps to column 0.
    logic [10:0] dx11, dy11, px11, py11;
    logic        in_box;
    logic [8:0]  col, row, col_m;

    always_comb begin
        dx11   = {1'b0, vid.draw_x};
        dy11   = {1'b0, vid.draw_y};
        px11   = {1'b0, pos_x_q};
        py11   = {1'b0, pos_y_q};
        in_box = vid.draw_en
               && (dx11 >= px11) && (dx11 < px11 + 11'(SPRITE_W))
               && (dy11 >= py11) && (dy11 < py11 + 11'(SPRITE_H));
        col    = 9'(vid.draw_x - pos_x_q);
        row    = 9'(vid.draw_y - pos_y_q);
        col_m  = (disp_mirror_q && (disp_state_q != ST_SQUISH)) ? 9'(SPRITE_W - 1) - col : col;
        read_address_d = in_box ? (row * 9'(SPRITE_W) + col_m) : 9'd0;
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= ST_WALK;
            squish_cnt_q   <= '0;
            anim_cnt_q     <= '0;
            mirror_q       <= 1'b0;
            pos_x_q        <= '0;
            pos_y_q        <= '0;
            disp_state_q   <= ST_WALK;
            disp_mirror_q  <= 1'b0;
            read_address_q <= '0;
            sprite_sel_q   <= 1'b0;
            hit_en_q       <= 1'b0;
            pixel_color_q  <= '0;
            pixel_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            squish_cnt_q <= squish_cnt_d;
            anim_cnt_q   <= anim_cnt_d;
            mirror_q     <= mirror_d;
            // Shadows take the pre-transition state but the freshly toggled mirror.
            if (vid.frame_start) begin
                pos_x_q       <= goomba_x_i;
                pos_y_q       <= goomba_y_i;
                disp_state_q  <= state_q;
                disp_mirror_q <= mirror_d;
            end
            read_address_q <= read_address_d;
            sprite_sel_q   <= (disp_state_q == ST_SQUISH);
            hit_en_q       <= in_box && (disp_state_q != ST_GONE);
            pixel_color_q  <= vid.color_in;
            pixel_hit_q    <= hit_en_q && (vid.color_in != KEY_COLOR);
        end
    end

    assign vid.read_address = read_address_q;
    assign vid.sprite_sel   = sprite_sel_q;
    assign vid.pixel_color  = pixel_color_q;
    assign vid.pixel_hit    = pixel_hit_q;
    assign gone_o           = (state_q == ST_GONE);
endmodule

// File: tb/tb_goomba_sprite_reader.sv
// Directed bench for goomba_sprite_reader: expected pixels queued at drive time,
// popped and compared as each pipeline stage produces them.
module tb_goomba_sprite_reader;
    localparam logic [23:0] OP  = 24'hE45810;
    localparam logic [23:0] KEY = 24'h800080;

    logic       clk_sys = 1'b0;
    logic       rst_b   = 1'b0;
    logic [9:0] goomba_x, goomba_y;
    logic       squish_req, respawn;
    logic       gone;

    goomba_sprite_reader_if vid();

    goomba_sprite_reader dut (
        .clk_sys      (clk_sys),
        .rst_b        (rst_b),
        .vid          (vid),
        .goomba_x_i   (goomba_x),
        .goomba_y_i   (goomba_y),
        .squish_req_i (squish_req),
        .respawn_i    (respawn),
        .gone_o       (gone)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [8:0]  addr;
        logic        sel;
        logic [23:0] color;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y, input logic en,
                         input logic [23:0] rom, input logic [8:0] ea, input logic es, input logic eh);
        exp_t e;
        @(negedge clk_sys);
        vid.draw_x  = x;
        vid.draw_y  = y;
        vid.draw_en = en;
        sb.push_back('{addr: ea, sel: es, color: rom, hit: eh});
        @(negedge clk_sys);
        vid.draw_en = 1'b0;
        e = sb.pop_front();
        check({tag, ".addr"}, 24'(vid.read_address), 24'(e.addr));
        check({tag, ".sel"},  24'(vid.sprite_sel),   24'(e.sel));
        vid.color_in = rom;
        @(negedge clk_sys);
        check({tag, ".color"}, vid.pixel_color,     e.color);
        check({tag, ".hit"},   24'(vid.pixel_hit),  24'(e.hit));
    endtask

    task automatic pulse(input logic fs, input logic sq, input logic rs);
        @(negedge clk_sys);
        vid.frame_start = fs;
        squish_req      = sq;
        respawn         = rs;
        @(negedge clk_sys);
        vid.frame_start = 1'b0;
        squish_req      = 1'b0;
        respawn         = 1'b0;
    endtask

    initial begin
        vid.frame_start = 1'b0;
        vid.draw_x      = '0;
        vid.draw_y      = '0;
        vid.draw_en     = 1'b0;
        vid.color_in    = '0;
        goomba_x        = 10'd100;
        goomba_y        = 10'd50;
        squish_req      = 1'b0;
        respawn         = 1'b0;

        repeat (3) @(negedge clk_sys);
        check("rst.addr",  24'(vid.read_address), 24'd0);
        check("rst.sel",   24'(vid.sprite_sel),   24'd0);
        check("rst.color", vid.pixel_color,       24'd0);
        check("rst.hit",   24'(vid.pixel_hit),    24'd0);
        check("rst.gone",  24'(gone),             24'd0);
        rst_b = 1'b1;

        pulse(1, 0, 0);                                       // frame 1
        pixel("origin",     100, 50, 1, OP,  9'd0,   0, 1);
        pixel("corner",     120, 70, 1, KEY, 9'd440, 0, 0);
        pixel("right_out",  121, 70, 1, OP,  9'd0,   0, 0);
        pixel("left_out",    99, 50, 1, OP,  9'd0,   0, 0);
        pixel("mid",        110, 60, 1, OP,  9'd220, 0, 1);
        pixel("bottom_out", 100, 71, 1, OP,  9'd0,   0, 0);
        pixel("no_en",      110, 60, 0, OP,  9'd0,   0, 0);

        goomba_x = 10'd1015;
        pulse(1, 0, 0);                                       // frame 2
        pixel("hi_x",      1020, 50, 1, OP, 9'd5, 0, 1);
        pixel("hi_x_last", 1023, 50, 1, OP, 9'd8, 0, 1);
        pixel("no_wrap",      3, 50, 1, OP, 9'd0, 0, 0);

        goomba_x = 10'd100;
        repeat (6) pulse(1, 0, 0);                            // frames 3..8
        pixel("mirror_on",   100, 50, 1, OP, 9'd20, 0, 1);
        pixel("mirror_r1c1", 101, 51, 1, OP, 9'd40, 0, 1);
        repeat (8) pulse(1, 0, 0);                            // frames 9..16
        pixel("mirror_off",  100, 50, 1, OP, 9'd0,  0, 1);

        goomba_x = 10'd200;
        pixel("tear_old",   100, 50, 1, OP, 9'd0, 0, 1);
        pixel("tear_new",   200, 50, 1, OP, 9'd0, 0, 0);
        pulse(1, 0, 0);
        pixel("tear_after", 200, 50, 1, OP, 9'd0, 0, 1);
        goomba_x = 10'd100;
        pulse(1, 0, 0);

        pulse(0, 1, 1);
        check("prio.gone", 24'(gone), 24'd0);
        pulse(1, 0, 0);
        pixel("prio", 100, 50, 1, OP, 9'd0, 0, 1);

        pulse(0, 1, 0);
        check("sq.gone0", 24'(gone), 24'd0);
        pixel("sq_pre", 100, 50, 1, OP, 9'd0, 0, 1);
        pulse(1, 0, 0);                                       // squish frame 1
        pixel("sq_sel", 100, 50, 1, OP,  9'd0,  1, 1);
        pixel("sq_key", 110, 50, 1, KEY, 9'd10, 1, 0);
        repeat (28) pulse(1, 0, 0);                           // squish frames 2..29
        check("sq.gone29", 24'(gone), 24'd0);
        pulse(1, 0, 0);                                       // squish frame 30
        check("sq.gone30", 24'(gone), 24'd1);
        pulse(1, 0, 0);
        pixel("gone_hit", 100, 50, 1, OP, 9'd0,   0, 0);
        pixel("gone_mid", 110, 60, 1, OP, 9'd220, 0, 0);

        pulse(0, 0, 1);
        check("resp.gone", 24'(gone), 24'd0);
        pulse(1, 0, 0);
        pixel("resp", 100, 50, 1, OP, 9'd0, 0, 1);

        pulse(1, 1, 0);
        check("sqf.gone", 24'(gone), 24'd0);
        pixel("sqf_walk", 100, 50, 1, OP, 9'd0, 0, 1);
        pulse(1, 0, 0);
        pixel("sqf_sel",  100, 50, 1, OP, 9'd0, 1, 1);
        pulse(0, 0, 1);

        @(negedge clk_sys);
        vid.draw_x   = 10'd110;
        vid.draw_y   = 10'd60;
        vid.draw_en  = 1'b1;
        vid.color_in = OP;
        @(posedge clk_sys);
        #2;
        check("pre_rst.addr", 24'(vid.read_address), 24'd220);
        rst_b = 1'b0;
        #1;
        check("mid_rst.addr",  24'(vid.read_address), 24'd0);
        check("mid_rst.color", vid.pixel_color,       24'd0);
        check("mid_rst.hit",   24'(vid.pixel_hit),    24'd0);
        vid.draw_en = 1'b0;
        @(negedge clk_sys);
        rst_b = 1'b1;
        pixel("post_rst", 5, 5, 1, OP, 9'd110, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
